// File: rtl/nrzi_pkg.sv
// nrzi_pkg: shared definitions for the NRZI toggle decoder.
//   - nrzi_state_t : decoder FSM states (IDLE, SHIFT)
//   - DEF_*        : default parameter values for the decoder and its synchronizer
//   - phase_width  : bit width of the in-bit phase counter for a given BIT_CYCLES
package nrzi_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } nrzi_state_t;

    localparam int DEF_BIT_CYCLES  = 4;
    localparam int DEF_WORD_W      = 8;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_CNT_W       = 16;

    // The phase counter must hold 0..bit_cycles-1; keep it at least 1 bit wide.
    function automatic int phase_width(input int bit_cycles);
        return (bit_cycles <= 2) ? 1 : $clog2(bit_cycles);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// sync_chain: multi-flop synchronizer for a single asynchronous input.
//   clk  in  : sampling clock
//   rst  in  : synchronous active-high reset, clears every stage to 0
//   d    in  : asynchronous input
//   q    out : d delayed by SYNC_STAGES flops
module sync_chain
    import nrzi_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] stage_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_reg <= '0;
        end else begin
            stage_reg <= {stage_reg[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stage_reg[SYNC_STAGES-1];

endmodule

// File: rtl/nrzi_toggle_decoder.sv
// nrzi_toggle_decoder: recovers t bits from a toggle-encoded (NRZI) line q_in
// at a fixed rate of BIT_CYCLES clocks per bit and packs them LSB-first into
// WORD_W-bit words presented on a valid/ready output.
//   clk        in  : single clock, all logic on posedge
//   rst        in  : synchronous active-high reset
//   en         in  : decode enable; dropping it discards the partial word
//   q_in       in  : toggle-encoded line, asynchronous to clk
//   out_ready  in  : consumer accepts out_data
//   clr_ovr    in  : pulse clearing overrun
//   out_valid  out : out_data holds an unconsumed word
//   out_data   out : recovered word, bit 0 = first received bit
//   t_pulse    out : one-cycle pulse per change of synchronized q
//   overrun    out : sticky, a completed word was dropped
//   toggle_cnt out : wrapping count of synchronized q changes
module nrzi_toggle_decoder
    import nrzi_pkg::*;
#(
    parameter int BIT_CYCLES  = DEF_BIT_CYCLES,
    parameter int WORD_W      = DEF_WORD_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              q_in,
    input  logic              out_ready,
    input  logic              clr_ovr,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data,
    output logic              t_pulse,
    output logic              overrun,
    output logic [CNT_W-1:0]  toggle_cnt
);

    localparam int PW = phase_width(BIT_CYCLES);
    localparam int BW = $clog2(WORD_W);

    localparam logic [PW-1:0]    PHASE_LAST = PW'(BIT_CYCLES - 1);
    localparam logic [PW-1:0]    PHASE_ONE  = PW'(1);
    localparam logic [BW-1:0]    BIT_LAST   = BW'(WORD_W - 1);
    localparam logic [BW-1:0]    BIT_ONE    = BW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic q_sync;

    sync_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (q_in),
        .q  (q_sync)
    );

    // Raw toggle detection runs regardless of en.
    logic             q_prev_reg;
    logic             t_pulse_reg;
    logic [CNT_W-1:0] toggle_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_prev_reg     <= 1'b0;
            t_pulse_reg    <= 1'b0;
            toggle_cnt_reg <= '0;
        end else begin
            q_prev_reg  <= q_sync;
            t_pulse_reg <= q_sync ^ q_prev_reg;
            if (t_pulse_reg) begin
                toggle_cnt_reg <= toggle_cnt_reg + CNT_ONE;
            end
        end
    end

    // Bit recovery FSM and output handshake state.
    nrzi_state_t       state_reg,     state_next;
    logic [PW-1:0]     phase_reg,     phase_next;
    logic [BW-1:0]     bit_cnt_reg,   bit_cnt_next;
    logic [WORD_W-1:0] shift_reg,     shift_next;
    logic              q_ref_reg,     q_ref_next;
    logic              out_valid_reg, out_valid_next;
    logic [WORD_W-1:0] out_data_reg,  out_data_next;
    logic              overrun_reg,   overrun_next;

    logic [WORD_W-1:0] shift_in;
    logic              word_done;
    logic              xfer;
    logic              load;

    // New bit enters at the MSB so that after WORD_W strobes the first bit is bit 0.
    assign shift_in = {q_sync ^ q_ref_reg, shift_reg[WORD_W-1:1]};

    always_comb begin
        state_next   = state_reg;
        phase_next   = phase_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        q_ref_next   = q_ref_reg;
        word_done    = 1'b0;
        case (state_reg)
            IDLE: begin
                phase_next   = '0;
                bit_cnt_next = '0;
                shift_next   = '0;
                // Tracking q here means the first strobe after enable only sees
                // changes that happened inside the first bit period.
                q_ref_next   = q_sync;
                if (en) begin
                    // The enabling cycle itself is phase 0 of the first bit.
                    state_next = SHIFT;
                    phase_next = PHASE_ONE;
                end
            end
            SHIFT: begin
                if (!en) begin
                    state_next   = IDLE;
                    phase_next   = '0;
                    bit_cnt_next = '0;
                    shift_next   = '0;
                    q_ref_next   = q_sync;
                end else if (phase_reg == PHASE_LAST) begin
                    phase_next = '0;
                    q_ref_next = q_sync;
                    shift_next = shift_in;
                    if (bit_cnt_reg == BIT_LAST) begin
                        word_done    = 1'b1;
                        bit_cnt_next = '0;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + BIT_ONE;
                    end
                end else begin
                    phase_next = phase_reg + PHASE_ONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        xfer = out_valid_reg & out_ready;
        // A completed word may load into the output slot when it is empty or
        // being emptied on this very edge; otherwise it is lost.
        load = word_done & (~out_valid_reg | xfer);

        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        overrun_next   = overrun_reg;

        if (load) begin
            out_valid_next = 1'b1;
            out_data_next  = shift_in;
        end else if (xfer) begin
            out_valid_next = 1'b0;
        end

        // A drop on the same edge as clr_ovr keeps the flag set.
        if (word_done && !load) begin
            overrun_next = 1'b1;
        end else if (clr_ovr) begin
            overrun_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            phase_reg     <= '0;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            q_ref_reg     <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            phase_reg     <= phase_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            q_ref_reg     <= q_ref_next;
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
            overrun_reg   <= overrun_next;
        end
    end

    assign out_valid  = out_valid_reg;
    assign out_data   = out_data_reg;
    assign t_pulse    = t_pulse_reg;
    assign overrun    = overrun_reg;
    assign toggle_cnt = toggle_cnt_reg;

endmodule

// File: tb/tb_nrzi_toggle_decoder.sv
// tb_nrzi_toggle_decoder: drives q_in from a T-flop model of a bit stream and
// checks recovered words through a scoreboard queue, plus handshake, overrun,
// toggle counter and reset behaviour.
module tb_nrzi_toggle_decoder;

    localparam int BC = 4;
    localparam int WW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          q_in;
    logic          out_ready;
    logic          clr_ovr;
    logic          out_valid;
    logic [WW-1:0] out_data;
    logic          t_pulse;
    logic          overrun;
    logic [15:0]   toggle_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_xfer_cyc = 0;
    int prev_xfer_cyc = 0;
    logic [WW-1:0] exp_q[$];

    nrzi_toggle_decoder #(
        .BIT_CYCLES (BC),
        .WORD_W     (WW),
        .SYNC_STAGES(2),
        .CNT_W      (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .q_in      (q_in),
        .out_ready (out_ready),
        .clr_ovr   (clr_ovr),
        .out_valid (out_valid),
        .out_data  (out_data),
        .t_pulse   (t_pulse),
        .overrun   (overrun),
        .toggle_cnt(toggle_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: a transfer happens on the next edge whenever valid and ready
    // are both high; compare against the oldest expected word.
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            check_eq("sb_avail", {31'd0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) begin
                logic [WW-1:0] e;
                e = exp_q.pop_front();
                $display("xfer cyc=%0d data=0x%02h exp=0x%02h", cyc, out_data, e);
                check_eq("sb_data", {24'd0, out_data}, {24'd0, e});
            end
            prev_xfer_cyc = last_xfer_cyc;
            last_xfer_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // T-flop model: toggle q_in at the start of each bit period whose t bit is 1.
    // mode 1: check out_valid still low one cycle before completion
    // mode 2: pulse out_ready exactly on the completion edge
    // mode 3: pulse clr_ovr exactly on the completion edge
    task automatic send_word(input logic [WW-1:0] w, input int mode);
        for (int i = 0; i < WW; i++) begin
            if (w[i]) q_in = ~q_in;
            for (int c = 0; c < BC; c++) begin
                if (i == WW-1 && c == BC-1) begin
                    if (mode == 1) check_eq("lat_pre", {31'd0, out_valid}, 32'd0);
                    if (mode == 2) out_ready = 1'b1;
                    if (mode == 3) clr_ovr = 1'b1;
                end
                tick();
                if (i == WW-1 && c == BC-1) begin
                    if (mode == 2) out_ready = 1'b0;
                    if (mode == 3) clr_ovr = 1'b0;
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] cnt0;

        // 1. Reset with q_in wiggling
        rst = 1'b1; en = 1'b0; q_in = 1'b0; out_ready = 1'b0; clr_ovr = 1'b0;
        tick(); q_in = 1'b1;
        tick(); q_in = 1'b0;
        check_eq("rst_valid",   {31'd0, out_valid}, 32'd0);
        check_eq("rst_data",    {24'd0, out_data},  32'd0);
        check_eq("rst_tpulse",  {31'd0, t_pulse},   32'd0);
        check_eq("rst_overrun", {31'd0, overrun},   32'd0);
        check_eq("rst_cnt",     {16'd0, toggle_cnt}, 32'd0);
        rst = 1'b0;
        repeat (3) tick();

        // 2. Basic decode with latency check
        en = 1'b1;
        exp_q.push_back(8'hA5);
        send_word(8'hA5, 1);
        en = 1'b0;
        check_eq("lat_post", {31'd0, out_valid}, 32'd1);
        check_eq("cnt_a5",   {16'd0, toggle_cnt}, 32'd4);
        out_ready = 1'b1;
        tick();
        check_eq("a5_drained", {31'd0, out_valid}, 32'd0);

        // 3. Back-to-back extremes
        cnt0 = toggle_cnt;
        en = 1'b1;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_word(8'h00, 0);
        send_word(8'hFF, 0);
        en = 1'b0;
        check_eq("cnt_ff", {16'd0, toggle_cnt}, {16'd0, cnt0 + 16'd8});
        tick();
        check_eq("b2b_spacing", last_xfer_cyc - prev_xfer_cyc, 32'd32);

        // 4. Backpressure and overrun
        out_ready = 1'b0;
        en = 1'b1;
        exp_q.push_back(8'h3C);
        send_word(8'h3C, 0);
        send_word(8'hC3, 0);
        en = 1'b0;
        check_eq("bp_valid",   {31'd0, out_valid}, 32'd1);
        check_eq("bp_data",    {24'd0, out_data},  32'h3C);
        check_eq("bp_overrun", {31'd0, overrun},   32'd1);
        clr_ovr = 1'b1; tick(); clr_ovr = 1'b0;
        check_eq("clr_overrun", {31'd0, overrun}, 32'd0);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        check_eq("bp_drained", {31'd0, out_valid}, 32'd0);

        // 5a. Accept and load on the same edge
        en = 1'b1;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h5A);
        send_word(8'h11, 0);
        send_word(8'h5A, 2);
        en = 1'b0;
        check_eq("sim_valid",   {31'd0, out_valid}, 32'd1);
        check_eq("sim_data",    {24'd0, out_data},  32'h5A);
        check_eq("sim_overrun", {31'd0, overrun},   32'd0);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // 5b. clr_ovr coincides with a drop
        en = 1'b1;
        exp_q.push_back(8'h21);
        send_word(8'h21, 0);
        send_word(8'h34, 3);
        en = 1'b0;
        check_eq("setwins_overrun", {31'd0, overrun},  32'd1);
        check_eq("setwins_data",    {24'd0, out_data}, 32'h21);
        clr_ovr = 1'b1; tick(); clr_ovr = 1'b0;
        out_ready = 1'b1; tick();

        // 6a. Abort after 3 bits, then a clean word
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i != 1) q_in = ~q_in;
            repeat (BC) tick();
        end
        en = 1'b0;
        repeat (6) tick();
        en = 1'b1;
        exp_q.push_back(8'h81);
        send_word(8'h81, 0);
        en = 1'b0;
        repeat (2) tick();
        check_eq("abort_sb_empty", exp_q.size(), 32'd0);
        check_eq("abort_overrun",  {31'd0, overrun}, 32'd0);

        // 6b. Reset mid-word
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            q_in = ~q_in;
            repeat (BC) tick();
        end
        rst = 1'b1; en = 1'b0;
        tick();
        check_eq("mid_rst_valid",  {31'd0, out_valid},  32'd0);
        check_eq("mid_rst_data",   {24'd0, out_data},   32'd0);
        check_eq("mid_rst_tpulse", {31'd0, t_pulse},    32'd0);
        check_eq("mid_rst_ovr",    {31'd0, overrun},    32'd0);
        check_eq("mid_rst_cnt",    {16'd0, toggle_cnt}, 32'd0);
        rst = 1'b0;
        repeat (4) tick();
        en = 1'b1;
        exp_q.push_back(8'h42);
        send_word(8'h42, 0);
        en = 1'b0;
        repeat (3) tick();
        check_eq("sb_drain", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nrzi_toggle_decoder.md
Name: nrzi_toggle_decoder

Overview:
- Receive-side counterpart of our toggle (T) storage elements.
- A T element driven by a bit stream t emits a line q that flips whenever t=1 (NRZI encoding). This block samples such a q line, recovers the t bits at a fixed bit rate, and packs them LSB-first into words.
- Words are presented on a valid/ready output. The block also reports every raw toggle as a pulse and keeps a running toggle count.
- Sits between a toggle-encoded serial line and any word-wide consumer.

Parameters:
- BIT_CYCLES, 4: clocks per bit period; legal range 4..256.
- WORD_W, 8: bits per output word; legal range 2..32.
- SYNC_STAGES, 2: flops in the q_in synchronizer; legal range 2..3.
- CNT_W, 16: width of toggle_cnt.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  decode enable.
- q_in  in  1  toggle-encoded line, asynchronous to clk.
- out_ready  in  1  consumer accepts out_data.
- clr_ovr  in  1  one-cycle pulse that clears overrun.
- out_valid  out  1  out_data holds an unconsumed word.
- out_data  out  WORD_W  recovered word; bit 0 is the first received bit.
- t_pulse  out  1  one-cycle pulse per change of synchronized q.
- overrun  out  1  sticky: a completed word was dropped.
- toggle_cnt  out  CNT_W  count of synchronized q changes; wraps.

Behaviour:
- Reset (rst=1 at posedge):
  - Clears synchronizer flops, q_ref, phase, bit_cnt, shift register, FSM (to IDLE) and all outputs to 0.
  - Reset takes priority over every other input, including mid-word and mid-handshake.
- Synchronizer: q_sync is q_in delayed by SYNC_STAGES flops.
- t_pulse and toggle_cnt:
  - t_pulse = q_sync XOR its previous value, registered, so it appears 1 cycle after q_sync changes.
  - toggle_cnt increments on each t_pulse, independent of en.
  - toggle_cnt wraps from all-ones to 0.
- FSM state IDLE (en=0):
  - phase=0, bit_cnt=0, shift register cleared.
  - q_ref tracks q_sync every cycle, so re-enabling never produces a spurious 1.
  - Transition to SHIFT when en=1.
- FSM state SHIFT (en=1):
  - phase counts 0..BIT_CYCLES-1 and wraps; the first enabled cycle has phase=0.
  - Sample strobe when phase=BIT_CYCLES-1: bit = q_sync XOR q_ref; q_ref <= q_sync; the bit shifts in at the MSB end so that bit 0 ends as the first bit; bit_cnt increments.
  - Word complete on the strobe where bit_cnt=WORD_W-1; bit_cnt returns to 0 on the same edge.
  - en=0 in any SHIFT cycle returns the FSM to IDLE next edge. The partial word is discarded; out_valid, out_data and overrun are unaffected.
- Output handshake:
  - A transfer occurs on an edge with out_valid=1 and out_ready=1; out_valid then falls unless a new word loads on that same edge.
  - out_data stays stable while out_valid=1 and no transfer has occurred.
  - On word completion, if out_valid=0 or a transfer occurs on the same edge: out_data <= word and out_valid=1 next cycle. Simultaneous accept plus load leaves out_valid continuously high with no overrun.
  - Otherwise the new word is dropped, out_data is kept, and overrun <= 1.
- overrun: cleared by clr_ovr. If clr_ovr and a new drop occur on the same edge, overrun stays 1 (set wins).
- Latency:
  - A q_in change applied at the start of bit period k is sampled correctly, because SYNC_STAGES < BIT_CYCLES.
  - out_valid rises 1 cycle after the final strobe: cycle E+WORD_W*BIT_CYCLES, where E is the first enabled cycle.

Decomposition:
- Package nrzi_pkg holds:
  - the FSM state enum (IDLE, SHIFT);
  - default parameter constants;
  - a function computing the counter width clog2(BIT_CYCLES).
- One sub-module, sync_chain (parameter SYNC_STAGES, reset to 0), used for q_in. Everything else lives in the top module.

Test Plan (BIT_CYCLES=4, WORD_W=8, SYNC_STAGES=2):
1. Reset: rst=1 for 2 cycles with q_in toggling -> out_valid=0, out_data=0x00, t_pulse=0, overrun=0, toggle_cnt=0.
2. Basic decode: en rises at cycle E; a T-flop model drives q_in with t bits for 0xA5 LSB-first, one bit per 4 clocks starting at E -> out_data=0xA5 with out_valid rising at E+32, and toggle_cnt=4.
3. Extremes: back-to-back words 0x00 (q_in constant) then 0xFF (q_in toggles every bit), out_ready=1 -> 0x00 then 0xFF, each valid 32 cycles apart; toggle_cnt increases by 8.
4. Backpressure: out_ready=0, send 0x3C then 0xC3 -> out_data stays 0x3C and overrun=1 after the second word. A clr_ovr pulse -> overrun=0. Raising out_ready transfers 0x3C.
5. Simultaneous events:
   - out_ready pulses on the exact completion edge of 0x5A while 0x11 is pending -> 0x11 accepted, 0x5A loaded, out_valid never drops, overrun=0.
   - clr_ovr coincides with a drop -> overrun=1.
6. Abort:
   - en drops after 3 bits, then re-enables and 0x81 is sent -> out_data=0x81 with no residue.
   - rst asserted mid-word -> all outputs 0 next cycle, and decoding resumes cleanly with 0x42.
